serial_parity_checker: RTL and testbench

//  Receives a serial frame: FRAME_LEN data bits, LSB first, then one parity bit.

---
 rtl/parity_pkg.sv | 11 +
 rtl/parity_xor_cell.sv | 17 +
 rtl/serial_parity_checker.sv | 99 +++++++++
 tb/tb_serial_parity_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity checker: FSM state encodings.
package parity_pkg;

  // Frame-reception phases. Encoding 2'd3 is unused and recovers to ST_COLLECT.
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_PARITY  = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage : parity_pkg

// File: rtl/parity_xor_cell.sv
// Single-bit XOR built purely from 2:1 multiplexers.
// The inverted operand comes from one mux and the select from a second mux.
module parity_xor_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  logic b_n;

  // First mux: select a constant by b to produce ~b.
  assign b_n = b ? 1'b0 : 1'b1;

  // Second mux: a picks between b and ~b, which is exactly a ^ b.
  assign y = a ? b_n : b;

endmodule : parity_xor_cell

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: FRAME_LEN data bits LSB first, then one parity bit.
// Deserialises the word, folds a running parity through mux-built XOR cells
// and presents the word plus a parity error flag on a valid/ready output.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int ODD       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_LEN-1:0] out_data,
  output logic                 out_parity_err
);

  localparam int             CW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic           ODD_BIT  = (ODD != 0);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   acc;
  logic [FRAME_LEN-1:0]   shift;
  logic                   accept;
  logic                   acc_next;
  logic                   err_next;

  // Ready is a pure state decode so it never loops back through in_valid.
  assign in_ready = (state == ST_COLLECT) || (state == ST_PARITY);
  assign accept   = in_valid & in_ready;

  // Running parity fold: acc ^ in_bit, used for both the acc update and the check.
  parity_xor_cell u_acc_xor (
    .a (acc),
    .b (in_bit),
    .y (acc_next)
  );

  // Error term: folded parity including the received parity bit, biased by ODD.
  parity_xor_cell u_err_xor (
    .a (acc_next),
    .b (ODD_BIT),
    .y (err_next)
  );

  // Frame FSM with counter, shift register and registered outputs.
  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; a blocking = would let later lines see updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_COLLECT;
      cnt            <= '0;
      acc            <= 1'b0;
      // NOTE: the shift register is small and explicitly cleared so no stale
      // bits from an aborted frame can ever appear in out_data.
      shift          <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_parity_err <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (accept) begin
            shift[cnt] <= in_bit;
            acc        <= acc_next;
            if (cnt == LAST_IDX) begin
              cnt   <= '0;
              state <= ST_PARITY;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (accept) begin
            out_data       <= shift;
            out_parity_err <= err_next;
            out_valid      <= 1'b1;
            acc            <= 1'b0;
            state          <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_COLLECT;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule : serial_parity_checker

// File: tb/tb_serial_parity_checker.sv
// Self-checking bench: an even-parity and an odd-parity instance share stimulus;
// expected words and error flags come from a whole-frame popcount model.
module tb_serial_parity_checker;

  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_bit;
  logic          out_ready;
  logic          ir_e, ov_e, pe_e;
  logic          ir_o, ov_o, pe_o;
  logic [FL-1:0] od_e, od_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.FRAME_LEN(FL), .ODD(0)) dut_even (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_bit         (in_bit),
    .in_ready       (ir_e),
    .out_valid      (ov_e),
    .out_ready      (out_ready),
    .out_data       (od_e),
    .out_parity_err (pe_e)
  );

  serial_parity_checker #(.FRAME_LEN(FL), .ODD(1)) dut_odd (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_bit         (in_bit),
    .in_ready       (ir_o),
    .out_valid      (ov_o),
    .out_ready      (out_ready),
    .out_data       (od_o),
    .out_parity_err (pe_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: error whenever the total count of ones (data + parity + ODD) is odd.
  function automatic logic model_err(input logic [FL-1:0] w, input logic p, input int odd);
    return ((($countones(w) + int'(p) + odd) % 2) != 0);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready_e"}, ir_e, 1'b1);
    check({tag, "_in_ready_o"}, ir_o, 1'b1);
    check({tag, "_out_valid_e"}, ov_e, 1'b0);
    check({tag, "_out_valid_o"}, ov_o, 1'b0);
  endtask

  task automatic check_result(input string tag, input logic [FL-1:0] w, input logic p);
    check({tag, "_valid_e"}, ov_e, 1'b1);
    check({tag, "_valid_o"}, ov_o, 1'b1);
    check({tag, "_data_e"}, od_e, w);
    check({tag, "_data_o"}, od_o, w);
    check({tag, "_err_e"}, pe_e, model_err(w, p, 0));
    check({tag, "_err_o"}, pe_o, model_err(w, p, 1));
    check({tag, "_in_ready_hold"}, ir_e, 1'b0);
  endtask

  // Send one frame. gap_max: 0 = back to back, 1 = exactly one idle cycle
  // between bits, >1 = random 0..gap_max idle cycles. exp_cycles < 0 skips timing.
  task automatic send_frame(input string tag, input logic [FL-1:0] w, input logic p,
                            input int gap_max, input int exp_cycles);
    int   cyc;
    int   n;
    logic b;
    cyc = 0;
    for (int i = 0; i <= FL; i++) begin
      b = (i < FL) ? w[i] : p;
      if (i > 0) begin
        n = (gap_max == 0) ? 0 : (gap_max == 1) ? 1 : int'($urandom_range(gap_max, 0));
        for (int g = 0; g < n; g++) begin
          in_valid  = 1'b0;
          in_bit    = 1'($urandom);
          out_ready = 1'($urandom);
          step();
          cyc++;
        end
      end
      in_valid  = 1'b1;
      in_bit    = b;
      out_ready = 1'($urandom);
      check_idle_outputs(tag);
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_result(tag, w, p);
    if (exp_cycles >= 0) check({tag, "_cycles"}, cyc, exp_cycles);
  endtask

  // Hold the result for 'stall' cycles with in_valid asserted, then hand it off.
  task automatic drain(input string tag, input logic [FL-1:0] w, input logic p, input int stall);
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_bit    = 1'($urandom);
      step();
      check_result({tag, "_stall"}, w, p);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    out_ready = 1'b0;
    check_idle_outputs({tag, "_drained"});
    check({tag, "_data_kept"}, od_e, w);
    check({tag, "_err_kept"}, pe_e, model_err(w, p, 0));
  endtask

  initial begin
    logic [FL-1:0] w;
    logic          p;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_idle_outputs("reset");
    check("reset_data", od_e, '0);
    check("reset_err", pe_e, 1'b0);

    // Even parity word with matching and mismatching parity bits.
    send_frame("t1", 8'hA5, 1'b0, 0, FL + 1);
    drain("t1", 8'hA5, 1'b0, 0);
    send_frame("t2", 8'hA5, 1'b1, 0, FL + 1);
    drain("t2", 8'hA5, 1'b1, 0);

    // Single set bit: the odd instance sees correct parity with p=0, error with p=1.
    send_frame("t3a", 8'h01, 1'b0, 0, FL + 1);
    drain("t3a", 8'h01, 1'b0, 0);
    send_frame("t3b", 8'h01, 1'b1, 0, FL + 1);
    drain("t3b", 8'h01, 1'b1, 0);

    // Backpressure: five stalled cycles consume nothing; next frame is intact.
    send_frame("t4", 8'hA5, 1'b0, 0, FL + 1);
    drain("t4", 8'hA5, 1'b0, 5);
    send_frame("t4_next", 8'h3C, 1'b1, 0, FL + 1);
    drain("t4_next", 8'h3C, 1'b1, 0);

    // Reset after three data bits, with a valid bit offered during reset.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_bit = 1'b1;
      step();
    end
    rst    = 1'b1;
    in_bit = 1'b0;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_idle_outputs("t5_rst");
    check("t5_rst_data", od_e, '0);
    send_frame("t5", 8'hFF, 1'b0, 0, FL + 1);
    drain("t5", 8'hFF, 1'b0, 0);

    // Reset during HOLD discards the pending result.
    send_frame("t5h", 8'h5A, 1'b1, 0, FL + 1);
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b0;
    check_idle_outputs("t5h_rst");
    check("t5h_rst_data", od_e, '0);
    check("t5h_rst_err", pe_e, 1'b0);

    // Alternating idle cycles: same result, accepts spread over 2*(FL+1)-1 edges.
    send_frame("t6", 8'hA5, 1'b0, 1, 2 * (FL + 1) - 1);
    drain("t6", 8'hA5, 1'b0, 0);

    // Random frames with random gaps and random output stalls.
    for (int k = 0; k < 20; k++) begin
      w = FL'($urandom);
      p = 1'($urandom);
      send_frame("rnd", w, p, 3, -1);
      drain("rnd", w, p, int'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_parity_checker
